// File: rtl/mem_arbiter.sv
// Two-requester arbiter (host, CPU) for a 4096x32 single-port memory, with a
// full-memory clear sweep and CPU anti-starvation.
module mem_arbiter (
  input  logic        main_clk,
  input  logic        reset,
  input  logic        clr_mem,
  input  logic        host_req,
  input  logic        host_rw,
  input  logic [11:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_gnt,
  output logic        host_rvalid,
  output logic [31:0] host_rdata,
  input  logic        cpu_req,
  input  logic        cpu_rw,
  input  logic [11:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  output logic        mem_en,
  output logic        mem_rw,
  output logic [11:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 2;

  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam logic [AW-1:0] LAST_ADDR    = {AW{1'b1}};
  localparam logic [CW-1:0] STARVE_LIMIT = CW'(2);

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] sweep_q, sweep_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          host_gnt_q, host_gnt_d;
  logic          cpu_gnt_q, cpu_gnt_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_rw_q, mem_rw_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          busy_q, busy_d;
  logic          host_rvalid_q, host_rvalid_d;
  logic          cpu_rvalid_q, cpu_rvalid_d;
  logic [DW-1:0] host_hold_q, host_hold_d;
  logic [DW-1:0] cpu_hold_q, cpu_hold_d;

  logic host_elig, cpu_elig, host_win, cpu_win;

  // A requester still seeing its grant this cycle is presenting a served request.
  assign host_elig = host_req & ~host_gnt_q;
  assign cpu_elig  = cpu_req & ~cpu_gnt_q;

  always_comb begin
    state_d       = state_q;
    sweep_d       = sweep_q;
    starve_d      = starve_q;
    host_gnt_d    = 1'b0;
    cpu_gnt_d     = 1'b0;
    mem_en_d      = 1'b0;
    mem_rw_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    busy_d        = 1'b0;
    host_win      = 1'b0;
    cpu_win       = 1'b0;
    host_rvalid_d = host_gnt_q & ~mem_rw_q;
    cpu_rvalid_d  = cpu_gnt_q & ~mem_rw_q;
    host_hold_d   = host_rvalid_q ? mem_rdata : host_hold_q;
    cpu_hold_d    = cpu_rvalid_q ? mem_rdata : cpu_hold_q;

    case (state_q)
      ST_ARB: begin
        if (clr_mem) begin
          state_d     = ST_CLEAR;
          sweep_d     = '0;
          mem_en_d    = 1'b1;
          mem_rw_d    = 1'b1;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          busy_d      = 1'b1;
        end else begin
          cpu_win  = cpu_elig & (~host_elig | (starve_q == STARVE_LIMIT));
          host_win = host_elig & ~cpu_win;
          if (host_win) begin
            host_gnt_d  = 1'b1;
            mem_en_d    = 1'b1;
            mem_rw_d    = host_rw;
            mem_addr_d  = host_addr;
            mem_wdata_d = host_wdata;
          end else if (cpu_win) begin
            cpu_gnt_d   = 1'b1;
            mem_en_d    = 1'b1;
            mem_rw_d    = cpu_rw;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
          end
        end
      end
      ST_CLEAR: begin
        // sweep_q is the address on the bus this cycle; it wraps to 0 on exit.
        sweep_d = sweep_q + AW'(1);
        if (sweep_q == LAST_ADDR) begin
          state_d = ST_ARB;
        end else begin
          mem_en_d    = 1'b1;
          mem_rw_d    = 1'b1;
          mem_addr_d  = sweep_q + AW'(1);
          mem_wdata_d = '0;
          busy_d      = 1'b1;
        end
      end
      default: state_d = ST_ARB;
    endcase

    if (cpu_win || !cpu_req) begin
      starve_d = '0;
    end else if (host_win && cpu_elig) begin
      starve_d = starve_q + CW'(1);
    end
  end

  always_ff @(posedge main_clk) begin
    if (reset) begin
      state_q       <= ST_ARB;
      sweep_q       <= '0;
      starve_q      <= '0;
      host_gnt_q    <= 1'b0;
      cpu_gnt_q     <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_rw_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      busy_q        <= 1'b0;
      host_rvalid_q <= 1'b0;
      cpu_rvalid_q  <= 1'b0;
      host_hold_q   <= '0;
      cpu_hold_q    <= '0;
    end else begin
      state_q       <= state_d;
      sweep_q       <= sweep_d;
      starve_q      <= starve_d;
      host_gnt_q    <= host_gnt_d;
      cpu_gnt_q     <= cpu_gnt_d;
      mem_en_q      <= mem_en_d;
      mem_rw_q      <= mem_rw_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      busy_q        <= busy_d;
      host_rvalid_q <= host_rvalid_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      host_hold_q   <= host_hold_d;
      cpu_hold_q    <= cpu_hold_d;
    end
  end

  assign host_gnt    = host_gnt_q;
  assign cpu_gnt     = cpu_gnt_q;
  assign mem_en      = mem_en_q;
  assign mem_rw      = mem_rw_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign busy        = busy_q;
  assign host_rvalid = host_rvalid_q;
  assign cpu_rvalid  = cpu_rvalid_q;
  // Memory data arrives the cycle after the read command, so rdata passes it
  // through while rvalid is high and otherwise shows the last captured value.
  assign host_rdata  = host_rvalid_q ? mem_rdata : host_hold_q;
  assign cpu_rdata   = cpu_rvalid_q ? mem_rdata : cpu_hold_q;

endmodule
